hamming_secded_decoder: RTL
===========================

HAMMING_SECDED_DECODER -- requirements
Module: hamming_secded_decoder

Interface
REQ-001 SHALL have parameter DATA_W, default 16, protected data width; only 16 is supported.
REQ-002 SHALL have parameter CHK_W, default 6, check width: 5 Hamming bits plus 1 overall parity bit.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 in_valid  in  1  input codeword valid.
REQ-006 in_ready  out  1  decoder can accept a codeword.
REQ-007 in_data  in  16  stored data word.
REQ-008 in_check  in  6  stored check bits.
REQ-009 out_valid  out  1  decoded result valid.
REQ-010 out_ready  in  1  downstream accepts the result.
REQ-011 out_data  out  16  corrected data.
REQ-012 out_check  out  6  check bits recomputed from out_data, for scrub write-back.
REQ-013 err_single  out  1  corrected single-bit error; qualified by out_valid.
REQ-014 err_double  out  1  uncorrectable error; qualified by out_valid.
REQ-015 syndrome  out  5  Hamming syndrome of the result word; qualified by out_valid.
REQ-016 clr_cnt  in  1  synchronous clear of the error counters.
REQ-017 single_cnt  out  8  saturating count of single errors.
REQ-018 double_cnt  out  8  saturating count of double errors.

Function
REQ-019 Code layout SHALL be Hamming positions 1..21:
- check[i] sits at position 2^i, for i = 0..4.
- data[0] at position 3; data[3:1] at positions 5..7; data[10:4] at positions 9..15; data[15:11] at positions 17..21.
- check[5] SHALL give even parity over all 22 bits.
REQ-020 Syndrome SHALL be the XOR of the position indices of all set bits in positions 1..21.
REQ-021 Let p = XOR of all 22 bits. Classification (s = syndrome):
- s=0, p=0: no error.
- s in 1..21, p=1: single error; flip the bit at position s.
- s=0, p=1: single error in check[5]; data unchanged.
- s!=0, p=0: double error; data passed through uncorrected.
- s in 22..31, p=1: double error; data passed through uncorrected.
REQ-022 Pipeline SHALL be two register stages:
- S1 captures the input word, syndrome and p.
- S2 holds the corrected data, out_check and flags.
- Latency SHALL be 2 cycles from the in_valid&&in_ready edge to out_valid, with no stall.
REQ-023 Stage-ready rules:
- S2 advances when !s2_valid || out_ready.
- S1 advances when !s1_valid || S2 advances.
- in_ready SHALL equal the S1 advance condition.
REQ-024 Throughput SHALL be one word per cycle while out_ready=1.
REQ-025 While out_valid=1 && out_ready=0, all out_* values and flags SHALL hold stable.
REQ-026 Counters SHALL increment once per transfer (out_valid && out_ready) whose err_single or err_double is set.
REQ-027 Counters SHALL saturate at 255.
REQ-028 clr_cnt SHALL take priority over a simultaneous increment; the counter reads 0 on the next cycle.

Reset
REQ-029 rst SHALL asynchronously clear s1_valid, s2_valid and both counters, and all data, flag and syndrome registers.
REQ-030 During reset, in_ready SHALL be 1 and out_valid SHALL be 0.
REQ-031 Words in flight when rst asserts SHALL be discarded and not counted.

Configuration
REQ-032 Macro HAMMING_ERR_CNT_EN:
- Defined: counters are implemented per REQ-026..028.
- Undefined: single_cnt and double_cnt SHALL be constant 0, clr_cnt SHALL be ignored, and no counter flops SHALL be inferred.
- Port list SHALL be identical in both cases.

Structure
REQ-033 Package hamming_pkg SHALL hold:
- DATA_W, CHK_W and the position map constants.
- Functions hamming_encode(data) -> check and hamming_syndrome(data, check) -> {p, s}.
- The shared encoder SHALL use the same functions.
REQ-034 Sub-module hamming_correct SHALL be the combinational S1->S2 corrector: bit flip plus classification.

Verification
REQ-035 Clean word: data 0x811A with encoded check, out_ready=1 -> out_data=0x811A 2 cycles later; err_single=0, err_double=0, syndrome=0; counters unchanged.
REQ-036 Single data error: data 0x811A with data[3] flipped (0x8112) -> out_data=0x811A, err_single=1, syndrome=7, single_cnt +1.
REQ-037 Single check error: check[5] flipped -> out_data=0x811A, err_single=1, syndrome=0; out_check = the original encoded check.
REQ-038 Double error: 0x811A with data[0] and data[15] flipped -> err_double=1, out_data=0x011B (uncorrected), double_cnt +1.
REQ-039 Backpressure: 4 back-to-back words with out_ready=0 for 3 cycles:
- in_ready falls after 2 accepts.
- Outputs hold stable while stalled.
- All 4 words emerge in order once out_ready=1.
REQ-040 Saturation/reset:
- 260 single-error words -> single_cnt=255.
- clr_cnt coincident with an error transfer -> counter reads 0.
- rst mid-stream -> out_valid=0 immediately; the stalled word is never output.

Source files
------------

// File: rtl/hamming_pkg.sv
// ============================================================================
// Module      : hamming_pkg
// Description : Shared constants and encode/syndrome functions for the
//               (22,16) Hamming SECDED code used by encoder and decoder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package hamming_pkg;

  localparam int DATA_W = 16;
  localparam int CHK_W  = 6;
  localparam int HAM_W  = 5;
  localparam int NPOS   = 21;

  // Hamming position of data[i] lives in bits [5*i +: 5]; powers of two are skipped.
  localparam logic [DATA_W*HAM_W-1:0] DATA_POS_MAP = {
    5'd21, 5'd20, 5'd19, 5'd18, 5'd17,
    5'd15, 5'd14, 5'd13, 5'd12, 5'd11, 5'd10, 5'd9,
    5'd7,  5'd6,  5'd5,
    5'd3
  };

  function automatic logic [HAM_W-1:0] data_pos(input int idx);
    return DATA_POS_MAP[idx*HAM_W +: HAM_W];
  endfunction

  // check[4:0] cancels the data positions' XOR; check[5] makes all 22 bits even.
  function automatic logic [CHK_W-1:0] hamming_encode(input logic [DATA_W-1:0] data);
    logic [HAM_W-1:0] s;
    logic             p;
    s = '0;
    for (int i = 0; i < DATA_W; i++) begin
      if (data[i]) s = s ^ data_pos(i);
    end
    p = (^data) ^ (^s);
    return {p, s};
  endfunction

  // Returns {overall parity, syndrome}.
  function automatic logic [CHK_W-1:0] hamming_syndrome(input logic [DATA_W-1:0] data,
                                                        input logic [CHK_W-1:0]  check);
    logic [HAM_W-1:0] s;
    logic             p;
    s = check[HAM_W-1:0];
    for (int i = 0; i < DATA_W; i++) begin
      if (data[i]) s = s ^ data_pos(i);
    end
    p = (^data) ^ (^check);
    return {p, s};
  endfunction

endpackage

`default_nettype wire

// File: rtl/hamming_correct.sv
// ============================================================================
// Module      : hamming_correct
// Description : Combinational corrector between decoder stages: single-bit
//               flip, error classification and scrub check regeneration.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hamming_correct
  import hamming_pkg::*;
(
  input  logic [DATA_W-1:0] data_i,
  input  logic [HAM_W-1:0]  syn_i,
  input  logic              par_i,
  output logic [DATA_W-1:0] data_o,
  output logic [CHK_W-1:0]  check_o,
  output logic              err_single_o,
  output logic              err_double_o
);

  always_comb begin
    data_o       = data_i;
    err_single_o = 1'b0;
    err_double_o = 1'b0;
    if (syn_i == '0) begin
      // Zero syndrome with odd parity means only check[5] flipped.
      err_single_o = par_i;
    end else if (par_i && (syn_i <= HAM_W'(NPOS))) begin
      err_single_o = 1'b1;
      for (int i = 0; i < DATA_W; i++) begin
        if (data_pos(i) == syn_i) data_o[i] = ~data_i[i];
      end
    end else begin
      err_double_o = 1'b1;
    end
  end

  assign check_o = hamming_encode(data_o);

endmodule

`default_nettype wire

// File: rtl/hamming_secded_decoder.sv
// ============================================================================
// Module      : hamming_secded_decoder
// Description : Two-stage valid/ready SECDED decoder with scrub check output.
//               Define HAMMING_ERR_CNT_EN to build the saturating error counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hamming_secded_decoder #(
  parameter int DATA_W = 16,
  parameter int CHK_W  = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CHK_W-1:0]  in_check,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CHK_W-1:0]  out_check,
  output logic              err_single,
  output logic              err_double,
  output logic [4:0]        syndrome,
  input  logic              clr_cnt,
  output logic [7:0]        single_cnt,
  output logic [7:0]        double_cnt
);

  import hamming_pkg::*;

  logic              s1_valid_q, s1_valid_d;
  logic [DATA_W-1:0] s1_data_q, s1_data_d;
  logic [4:0]        s1_syn_q, s1_syn_d;
  logic              s1_par_q, s1_par_d;

  logic              s2_valid_q, s2_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [CHK_W-1:0]  out_check_q, out_check_d;
  logic              err_single_q, err_single_d;
  logic              err_double_q, err_double_d;
  logic [4:0]        syn_q, syn_d;

  logic              s1_adv, s2_adv;
  logic [CHK_W-1:0]  in_ps;
  logic [DATA_W-1:0] corr_data;
  logic [CHK_W-1:0]  corr_check;
  logic              corr_single, corr_double;

  assign s2_adv   = !s2_valid_q || out_ready;
  assign s1_adv   = !s1_valid_q || s2_adv;
  assign in_ready = s1_adv;
  assign in_ps    = hamming_syndrome(in_data, in_check);

  hamming_correct u_correct (
    .data_i       (s1_data_q),
    .syn_i        (s1_syn_q),
    .par_i        (s1_par_q),
    .data_o       (corr_data),
    .check_o      (corr_check),
    .err_single_o (corr_single),
    .err_double_o (corr_double)
  );

  always_comb begin
    s1_valid_d   = s1_valid_q;
    s1_data_d    = s1_data_q;
    s1_syn_d     = s1_syn_q;
    s1_par_d     = s1_par_q;
    s2_valid_d   = s2_valid_q;
    out_data_d   = out_data_q;
    out_check_d  = out_check_q;
    err_single_d = err_single_q;
    err_double_d = err_double_q;
    syn_d        = syn_q;
    if (s1_adv) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_data_d = in_data;
        s1_syn_d  = in_ps[4:0];
        s1_par_d  = in_ps[5];
      end
    end
    // S2 registers only change on advance, so stalled outputs hold stable.
    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_data_d   = corr_data;
        out_check_d  = corr_check;
        err_single_d = corr_single;
        err_double_d = corr_double;
        syn_d        = s1_syn_q;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q   <= 1'b0;
      s1_data_q    <= '0;
      s1_syn_q     <= '0;
      s1_par_q     <= 1'b0;
      s2_valid_q   <= 1'b0;
      out_data_q   <= '0;
      out_check_q  <= '0;
      err_single_q <= 1'b0;
      err_double_q <= 1'b0;
      syn_q        <= '0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_data_q    <= s1_data_d;
      s1_syn_q     <= s1_syn_d;
      s1_par_q     <= s1_par_d;
      s2_valid_q   <= s2_valid_d;
      out_data_q   <= out_data_d;
      out_check_q  <= out_check_d;
      err_single_q <= err_single_d;
      err_double_q <= err_double_d;
      syn_q        <= syn_d;
    end
  end

  assign out_valid  = s2_valid_q;
  assign out_data   = out_data_q;
  assign out_check  = out_check_q;
  assign err_single = err_single_q;
  assign err_double = err_double_q;
  assign syndrome   = syn_q;

`ifdef HAMMING_ERR_CNT_EN
  logic [7:0] single_cnt_q, single_cnt_d;
  logic [7:0] double_cnt_q, double_cnt_d;
  logic       xfer;

  assign xfer = s2_valid_q && out_ready;

  always_comb begin
    single_cnt_d = single_cnt_q;
    double_cnt_d = double_cnt_q;
    if (clr_cnt) begin
      single_cnt_d = '0;
      double_cnt_d = '0;
    end else if (xfer) begin
      if (err_single_q && (single_cnt_q != 8'hFF)) single_cnt_d = single_cnt_q + 8'd1;
      if (err_double_q && (double_cnt_q != 8'hFF)) double_cnt_d = double_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      single_cnt_q <= '0;
      double_cnt_q <= '0;
    end else begin
      single_cnt_q <= single_cnt_d;
      double_cnt_q <= double_cnt_d;
    end
  end

  assign single_cnt = single_cnt_q;
  assign double_cnt = double_cnt_q;
`else
  logic unused_clr_cnt;
  assign unused_clr_cnt = clr_cnt;
  assign single_cnt     = '0;
  assign double_cnt     = '0;
`endif

endmodule

`default_nettype wire
